// File: rtl/irq_concat_pkg.sv
// Shared constants and the lowest-index priority encoder for the interrupt collector
// and future PLIC-lite blocks.
package irq_concat_pkg;

    localparam int IRQ_MAX_CH              = 64;
    localparam int IRQ_IDX_W               = 6;
    localparam int IRQ_DEFAULT_NUM_CH      = 16;
    localparam int IRQ_DEFAULT_SYNC_STAGES = 2;

    // Lowest set bit wins; an all-zero vector encodes to 0.
    function automatic logic [IRQ_IDX_W-1:0] irq_lowest_index(input logic [IRQ_MAX_CH-1:0] vec);
        logic [IRQ_IDX_W-1:0] idx;
        idx = '0;
        for (int i = IRQ_MAX_CH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IRQ_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_cc_sync.sv
// Single-bit synchroniser chain of STAGES flops with asynchronous active-low reset.
module irq_cc_sync #(
    parameter int STAGES = 2
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/irq_concat_ctrl.sv
// Interrupt collector: per-channel sync, edge/level capture, pending vector, prioritised ID.
// Define IRQ_CONCAT_SYNC_EN to synchronise irq_in; otherwise irq_in is taken as aclk-synchronous.
module irq_concat_ctrl
    import irq_concat_pkg::*;
#(
    parameter  int NUM_CH      = IRQ_DEFAULT_NUM_CH,
    parameter  int SYNC_STAGES = IRQ_DEFAULT_SYNC_STAGES,
    localparam int ID_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [NUM_CH-1:0] irq_in,
    input  logic [NUM_CH-1:0] edge_sel,
    input  logic [NUM_CH-1:0] mask,
    input  logic              claim_ack,
    output logic [NUM_CH-1:0] pend,
    output logic              irq_out,
    output logic              irq_id_valid,
    output logic [ID_W-1:0]   irq_id
);

    logic [NUM_CH-1:0] s;
    logic [NUM_CH-1:0] s_d;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] clr;
    logic [NUM_CH-1:0] pend_next;
    logic [IRQ_MAX_CH-1:0] active;

`ifdef IRQ_CONCAT_SYNC_EN
    localparam int WARM = SYNC_STAGES + 1;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_sync
        irq_cc_sync #(
            .STAGES(SYNC_STAGES)
        ) u_sync (
            .aclk   (aclk),
            .aresetn(aresetn),
            .d      (irq_in[i]),
            .q      (s[i])
        );
    end
`else
    localparam int WARM = 1;
    localparam int unused_sync_stages = SYNC_STAGES;

    assign s = irq_in;
`endif

    // Edge events stay suppressed until s_d has caught up with the reset-filled
    // chain, so a line already high at release is not seen as a rising edge.
    logic [WARM-1:0] arm;
    logic            armed;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            arm <= '0;
            s_d <= '0;
        end else begin
            arm <= (arm << 1) | WARM'(1);
            s_d <= s;
        end
    end

    assign armed = arm[WARM-1];
    assign rise  = s & ~s_d & {NUM_CH{armed}};

    // A set on the same edge as a claim keeps the bit, so no event is lost.
    always_comb begin
        clr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (claim_ack && irq_id_valid && (irq_id == ID_W'(i))) begin
                clr[i] = 1'b1;
            end
        end
        pend_next = (edge_sel & (rise | (pend & ~clr))) | (~edge_sel & s);
    end

    assign active = IRQ_MAX_CH'(pend & mask);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pend         <= '0;
            irq_out      <= 1'b0;
            irq_id_valid <= 1'b0;
            irq_id       <= '0;
        end else begin
            pend         <= pend_next;
            irq_out      <= |active;
            irq_id_valid <= |active;
            irq_id       <= ID_W'(irq_lowest_index(active));
        end
    end

endmodule

// File: tb/tb_irq_concat_ctrl.sv
// Scoreboard bench for irq_concat_ctrl: stimulus queues expected snapshots per cycle,
// a monitor compares them on the falling edge. Latency follows IRQ_CONCAT_SYNC_EN.
module tb_irq_concat_ctrl;

    localparam int NUM_CH      = 16;
    localparam int SYNC_STAGES = 2;
`ifdef IRQ_CONCAT_SYNC_EN
    localparam int LAT = SYNC_STAGES;
`else
    localparam int LAT = 0;
`endif

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [NUM_CH-1:0] irq_in;
    logic [NUM_CH-1:0] edge_sel;
    logic [NUM_CH-1:0] mask;
    logic              claim_ack;
    logic [NUM_CH-1:0] pend;
    logic              irq_out;
    logic              irq_id_valid;
    logic [3:0]        irq_id;

    typedef struct {
        int          cyc;
        string       name;
        logic [15:0] pend;
        logic        out;
        logic [3:0]  id;
    } exp_t;

    exp_t sb[$];
    int   cyc         = 0;
    int   vectors     = 0;
    int   miscompares = 0;

    irq_concat_ctrl #(
        .NUM_CH     (NUM_CH),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .irq_in      (irq_in),
        .edge_sel    (edge_sel),
        .mask        (mask),
        .claim_ack   (claim_ack),
        .pend        (pend),
        .irq_out     (irq_out),
        .irq_id_valid(irq_id_valid),
        .irq_id      (irq_id)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] irq, input logic [15:0] es,
                                 input logic [15:0] mk, input logic ack);
        irq_in    = irq;
        edge_sel  = es;
        mask      = mk;
        claim_ack = ack;
    endtask

    // Queue the expected outputs for the cycle `offset` cycles from now.
    task automatic checkOutput(input string name, input int offset, input logic [15:0] p,
                               input logic o, input logic [3:0] id);
        exp_t e;
        e.cyc  = cyc + offset;
        e.name = name;
        e.pend = p;
        e.out  = o;
        e.id   = id;
        sb.push_back(e);
    endtask

    initial begin
        forever begin
            @(negedge aclk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc <= cyc) begin
                    vectors++;
                    if (sb[i].cyc < cyc) begin
                        miscompares++;
                        $display("[TB] FAIL %s: expectation for cycle %0d not examined (now %0d)",
                                 sb[i].name, sb[i].cyc, cyc);
                    end else if (pend !== sb[i].pend || irq_out !== sb[i].out ||
                                 irq_id_valid !== sb[i].out || irq_id !== sb[i].id) begin
                        miscompares++;
                        $display("[TB] FAIL %s @%0d: got pend=%h out=%b valid=%b id=%0d, expected pend=%h out=%b valid=%b id=%0d",
                                 sb[i].name, cyc, pend, irq_out, irq_id_valid, irq_id,
                                 sb[i].pend, sb[i].out, sb[i].out, sb[i].id);
                    end
                    sb.delete(i);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        aresetn = 1'b0;
        applyStimulus(16'h0000, 16'h0000, 16'hFFFF, 1'b0);
        tick(3);
        aresetn = 1'b1;
        checkOutput("reset_state", 0, 16'h0000, 1'b0, 4'd0);
        tick(6);

        // Edge capture on channel 3, then claim.
        applyStimulus(16'h0008, 16'h0008, 16'hFFFF, 1'b0);
        checkOutput("edge_not_yet", LAT,     16'h0000, 1'b0, 4'd0);
        checkOutput("edge_pend",    LAT + 1, 16'h0008, 1'b0, 4'd0);
        checkOutput("edge_irq",     LAT + 2, 16'h0008, 1'b1, 4'd3);
        tick(3);
        applyStimulus(16'h0000, 16'h0008, 16'hFFFF, 1'b0);
        tick(LAT + 1);
        applyStimulus(16'h0000, 16'h0008, 16'hFFFF, 1'b1);
        checkOutput("edge_claim_hold", 0, 16'h0008, 1'b1, 4'd3);
        checkOutput("edge_claim_pend", 1, 16'h0000, 1'b1, 4'd3);
        checkOutput("edge_claim_irq",  2, 16'h0000, 1'b0, 4'd0);
        tick(1);
        applyStimulus(16'h0000, 16'h0008, 16'hFFFF, 1'b0);
        tick(3);

        // Level mode and priority: channels 5 and 9.
        applyStimulus(16'h0220, 16'h0000, 16'hFFFF, 1'b0);
        checkOutput("lvl_pend", LAT + 1, 16'h0220, 1'b0, 4'd0);
        checkOutput("lvl_prio", LAT + 2, 16'h0220, 1'b1, 4'd5);
        tick(LAT + 3);
        applyStimulus(16'h0220, 16'h0000, 16'hFFFF, 1'b1);
        checkOutput("lvl_claim_1", 1, 16'h0220, 1'b1, 4'd5);
        checkOutput("lvl_claim_2", 2, 16'h0220, 1'b1, 4'd5);
        tick(1);
        applyStimulus(16'h0220, 16'h0000, 16'hFFFF, 1'b0);
        tick(2);
        applyStimulus(16'h0200, 16'h0000, 16'hFFFF, 1'b0);
        checkOutput("lvl_drop_pend", LAT + 1, 16'h0200, 1'b1, 4'd5);
        checkOutput("lvl_next_id",   LAT + 2, 16'h0200, 1'b1, 4'd9);
        tick(LAT + 3);
        applyStimulus(16'h0000, 16'h0000, 16'hFFFF, 1'b0);
        checkOutput("lvl_idle", LAT + 2, 16'h0000, 1'b0, 4'd0);
        tick(LAT + 3);

        // Masked channel 2 records but stays quiet until unmasked.
        applyStimulus(16'h0004, 16'h0004, 16'hFFFB, 1'b0);
        checkOutput("mask_pend",  LAT + 1, 16'h0004, 1'b0, 4'd0);
        checkOutput("mask_quiet", LAT + 2, 16'h0004, 1'b0, 4'd0);
        tick(3);
        applyStimulus(16'h0000, 16'h0004, 16'hFFFB, 1'b0);
        tick(LAT + 1);
        applyStimulus(16'h0000, 16'h0004, 16'hFFFF, 1'b0);
        checkOutput("unmask_now", 0, 16'h0004, 1'b0, 4'd0);
        checkOutput("unmask_irq", 1, 16'h0004, 1'b1, 4'd2);
        tick(2);
        applyStimulus(16'h0000, 16'h0004, 16'hFFFF, 1'b1);
        checkOutput("mask_claim_pend", 1, 16'h0000, 1'b1, 4'd2);
        checkOutput("mask_claim_irq",  2, 16'h0000, 1'b0, 4'd0);
        tick(1);
        applyStimulus(16'h0000, 16'h0004, 16'hFFFF, 1'b0);
        tick(3);

        // Second channel 7 event lands on the claim edge.
        applyStimulus(16'h0080, 16'h0080, 16'hFFFF, 1'b0);
        tick(2);
        applyStimulus(16'h0000, 16'h0080, 16'hFFFF, 1'b0);
        tick(LAT + 2);
        checkOutput("coll_first", 0, 16'h0080, 1'b1, 4'd7);
        applyStimulus(16'h0080, 16'h0080, 16'hFFFF, 1'b0);
        tick(LAT);
        applyStimulus(16'h0080, 16'h0080, 16'hFFFF, 1'b1);
        checkOutput("coll_pend", 1, 16'h0080, 1'b1, 4'd7);
        checkOutput("coll_irq",  2, 16'h0080, 1'b1, 4'd7);
        tick(1);
        applyStimulus(16'h0080, 16'h0080, 16'hFFFF, 1'b0);
        tick(2);
        applyStimulus(16'h0000, 16'h0080, 16'hFFFF, 1'b0);
        tick(LAT + 2);
        applyStimulus(16'h0000, 16'h0080, 16'hFFFF, 1'b1);
        checkOutput("coll_clean_pend", 1, 16'h0000, 1'b1, 4'd7);
        checkOutput("coll_clean_irq",  2, 16'h0000, 1'b0, 4'd0);
        tick(1);
        applyStimulus(16'h0000, 16'h0080, 16'hFFFF, 1'b0);
        tick(3);

        // Reset mid-operation with several channels pending.
        applyStimulus(16'h0013, 16'hFFFF, 16'hFFFF, 1'b0);
        checkOutput("rst_pre", LAT + 2, 16'h0013, 1'b1, 4'd0);
        tick(LAT + 3);
        applyStimulus(16'h0001, 16'hFFFF, 16'hFFFF, 1'b0);
        #2;
        aresetn = 1'b0;
        checkOutput("rst_async", 0, 16'h0000, 1'b0, 4'd0);
        checkOutput("rst_hold",  1, 16'h0000, 1'b0, 4'd0);
        tick(3);
        aresetn = 1'b1;
        checkOutput("rst_rel_a", LAT + 1, 16'h0000, 1'b0, 4'd0);
        checkOutput("rst_rel_b", LAT + 2, 16'h0000, 1'b0, 4'd0);
        checkOutput("rst_rel_c", LAT + 4, 16'h0000, 1'b0, 4'd0);
        tick(LAT + 6);
        applyStimulus(16'h0000, 16'hFFFF, 16'hFFFF, 1'b0);
        tick(3);

        for (int i = 0; i < sb.size(); i++) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s: expectation for cycle %0d left unchecked", sb[i].name, sb[i].cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
